// File: rtl/vga_text_pkg.sv
// Shared helpers for the text-mode pixel pipeline: colour-word slicing,
// sync idle level and character-code range checking.
package vga_text_pkg;

  // Colour word is {R, G, B} with R in the most significant channel.
  function automatic int red_lsb(input int ch_w);
    return 2 * ch_w;
  endfunction

  function automatic int green_lsb(input int ch_w);
    return ch_w;
  endfunction

  function automatic int blue_lsb(input int ch_w);
    return 0 * ch_w;
  endfunction

  function automatic logic sync_idle(input int active_low);
    return (active_low != 0);
  endfunction

  function automatic logic glyph_in_range(input int code, input int first, input int num);
    return (code >= first) && (code < first + num);
  endfunction

endpackage

// File: rtl/vga_text_delay.sv
// Fixed-depth shift register used to align sideband signals with font ROM latency.
module vga_text_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] taps_p [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) taps_p[i] <= RESET_VAL;
    end else begin
      taps_p[0] <= data;
      for (int i = 1; i < DEPTH; i++) taps_p[i] <= taps_p[i-1];
    end
  end

  assign delayed = taps_p[DEPTH-1];

endmodule

// File: rtl/vga_text_pipe.sv
// Text-mode pixel renderer: character code to font ROM address, sideband aligned
// to ROM latency, then blink / reverse / cursor colour resolve and output register.
module vga_text_pipe
  import vga_text_pkg::*;
#(
  parameter int GLYPH_W          = 16,
  parameter int ROW_W            = 5,
  parameter int CODE_W           = 7,
  parameter int FIRST_CODE       = 32,
  parameter int NUM_GLYPHS       = 64,
  parameter int CH_W             = 4,
  parameter int ROM_LATENCY      = 1,
  parameter int BLINK_FRAMES     = 30,
  parameter int CURSOR_FIRST_ROW = 28,
  parameter int SYNC_ACTIVE_LOW  = 1
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   H_input,
  input  logic                                   V_input,
  input  logic                                   picture,
  input  logic [ROW_W-1:0]                       row,
  input  logic [$clog2(GLYPH_W)-1:0]             column,
  input  logic [CODE_W-1:0]                      character,
  input  logic [3*CH_W-1:0]                      foreground,
  input  logic [3*CH_W-1:0]                      background,
  input  logic                                   blink,
  input  logic                                   reverse,
  input  logic                                   cursor,
  input  logic [GLYPH_W-1:0]                     Character_Data,
  output logic [$clog2(NUM_GLYPHS)+ROW_W-1:0]    Character_Address,
  output logic [CH_W-1:0]                        R,
  output logic [CH_W-1:0]                        G,
  output logic [CH_W-1:0]                        B,
  output logic                                   H_output,
  output logic                                   V_output,
  output logic                                   blink_phase
);

  localparam int   COL_W     = $clog2(GLYPH_W);
  localparam int   GI_W      = $clog2(NUM_GLYPHS);
  localparam int   CW        = 3 * CH_W;
  localparam int   SIDE_W    = 1 + COL_W + ROW_W + 2 * CW + 3;
  localparam int   BC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int   R_LSB     = red_lsb(CH_W);
  localparam int   G_LSB     = green_lsb(CH_W);
  localparam int   B_LSB     = blue_lsb(CH_W);
  localparam logic SYNC_IDLE = sync_idle(SYNC_ACTIVE_LOW);

  // ---- stage p0: glyph lookup, out-of-range codes fall back to glyph 0 ----
  logic [GI_W-1:0] glyph_p0;

  always_comb begin
    glyph_p0 = '0;
    if (glyph_in_range(int'(character), FIRST_CODE, NUM_GLYPHS))
      glyph_p0 = GI_W'(int'(character) - FIRST_CODE);
  end

  assign Character_Address = {glyph_p0, row};

  // ---- stage p1: sideband delayed to meet Character_Data ----
  logic [SIDE_W-1:0] side_p0;
  logic [SIDE_W-1:0] side_p1;
  logic [1:0]        sync_p1;
  logic              vld_p1;
  logic [COL_W-1:0]  column_p1;
  logic [ROW_W-1:0]  row_p1;
  logic [CW-1:0]     fg_p1;
  logic [CW-1:0]     bg_p1;
  logic              blink_p1;
  logic              reverse_p1;
  logic              cursor_p1;

  assign side_p0 = {picture, column, row, foreground, background, blink, reverse, cursor};

  vga_text_delay #(
    .WIDTH     (SIDE_W),
    .DEPTH     (ROM_LATENCY),
    .RESET_VAL ({SIDE_W{1'b0}})
  ) u_side_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (side_p0),
    .delayed (side_p1)
  );

  vga_text_delay #(
    .WIDTH     (2),
    .DEPTH     (ROM_LATENCY),
    .RESET_VAL ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .data    ({H_input, V_input}),
    .delayed (sync_p1)
  );

  assign {vld_p1, column_p1, row_p1, fg_p1, bg_p1, blink_p1, reverse_p1, cursor_p1} = side_p1;

  logic [COL_W-1:0] bit_idx_p1;
  logic             pix_p1;
  logic             on_p1;
  logic [CW-1:0]    fg_sel_p1;
  logic [CW-1:0]    bg_sel_p1;
  logic [CW-1:0]    colour_p1;

  // MSB of the ROM row is the leftmost pixel; columns past the glyph are blank.
  always_comb begin
    bit_idx_p1 = COL_W'(GLYPH_W - 1) - column_p1;
    pix_p1     = 1'b0;
    if (int'(column_p1) < GLYPH_W)
      pix_p1 = Character_Data[bit_idx_p1];
  end

  always_comb begin
    fg_sel_p1 = reverse_p1 ? bg_p1 : fg_p1;
    bg_sel_p1 = reverse_p1 ? fg_p1 : bg_p1;
    on_p1     = pix_p1 & ~(blink_p1 & blink_phase);
    if (cursor_p1 && (int'(row_p1) >= CURSOR_FIRST_ROW) && !blink_phase)
      on_p1 = 1'b1;
    colour_p1 = vld_p1 ? (on_p1 ? fg_sel_p1 : bg_sel_p1) : '0;
  end

  // ---- stage p2: output register ----
  logic [CW-1:0] colour_p2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      colour_p2 <= '0;
      H_output  <= SYNC_IDLE;
      V_output  <= SYNC_IDLE;
    end else begin
      colour_p2 <= colour_p1;
      H_output  <= sync_p1[1];
      V_output  <= sync_p1[0];
    end
  end

  assign R = colour_p2[R_LSB +: CH_W];
  assign G = colour_p2[G_LSB +: CH_W];
  assign B = colour_p2[B_LSB +: CH_W];

  // Blink phase advances on the assertion edge of the raw vertical sync.
  logic            v_act;
  logic            v_act_q;
  logic            frame_edge;
  logic [BC_W-1:0] frame_cnt;

  assign v_act      = V_input ^ SYNC_IDLE;
  assign frame_edge = v_act & ~v_act_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_act_q     <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      v_act_q <= v_act;
      if (frame_edge) begin
        if (frame_cnt == BC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + BC_W'(1);
        end
      end
    end
  end

endmodule
